// File: rtl/i_cache_if.sv
// Fetch-side and refill-side signals between the instruction fetch stage,
// the direct-mapped instruction cache and backing memory.
interface i_cache_if;
    logic          proc_read;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_rdata;
    logic          proc_stall;
    logic          mem_read;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    // Cache side
    modport slave (
        input  proc_read,
        input  proc_addr,
        output proc_rdata,
        output proc_stall,
        output mem_read,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready
    );

    // Fetch stage and memory side, seen as a single requester/responder
    modport master (
        output proc_read,
        output proc_addr,
        input  proc_rdata,
        input  proc_stall,
        input  mem_read,
        input  mem_addr,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache with 4-word lines, zero-latency
// hits and a blocking two-state refill controller.
module i_cache #(
    parameter int NUM_LINES = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    i_cache_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [27:0]            miss_addr_q, miss_addr_d;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   fill_mask;

    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
    logic [127:0]           data_mem [NUM_LINES];

    logic [1:0]             req_offset;
    logic [IDX_W-1:0]       req_index;
    logic [TAG_W-1:0]       req_tag;
    logic [127:0]           req_line;
    logic                   hit;

    logic [IDX_W-1:0]       fill_index;
    logic [TAG_W-1:0]       fill_tag;
    logic                   fill_en;

    logic                   stall_d;
    logic                   mem_read_d;
    logic [27:0]            mem_addr_d;

    // ---------------- lookup ----------------
    assign req_offset = bus.proc_addr[1:0];
    assign req_index  = bus.proc_addr[IDX_W+1:2];
    assign req_tag    = bus.proc_addr[29:IDX_W+2];

    assign req_line = data_mem[req_index];
    assign hit      = valid_q[req_index] && (tag_mem[req_index] == req_tag);

    always_comb begin
        bus.proc_rdata = req_line[31:0];
        case (req_offset)
            2'd0: bus.proc_rdata = req_line[31:0];
            2'd1: bus.proc_rdata = req_line[63:32];
            2'd2: bus.proc_rdata = req_line[95:64];
            2'd3: bus.proc_rdata = req_line[127:96];
            default: bus.proc_rdata = req_line[31:0];
        endcase
    end

    // ---------------- refill write ----------------
    assign fill_index = miss_addr_q[IDX_W-1:0];
    assign fill_tag   = miss_addr_q[27:IDX_W];
    // mem_ready outside REFILL must never touch the arrays
    assign fill_en    = (state_q == REFILL) && bus.mem_ready;

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_fill_mask
            assign fill_mask[gi] = fill_en && (fill_index == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[fill_index] <= bus.mem_rdata;
            tag_mem[fill_index]  <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_q | fill_mask;
        end
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        stall_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_addr_d  = '0;
        case (state_q)
            IDLE: begin
                if (bus.proc_read && !hit) begin
                    stall_d     = 1'b1;
                    miss_addr_d = bus.proc_addr[29:2];
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                stall_d    = 1'b1;
                mem_read_d = 1'b1;
                mem_addr_d = miss_addr_q;
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall is a combinational function of proc_read, so it is gated with the
    // reset level to read 0 while rst_n is low even if a request is pending.
    assign bus.proc_stall = stall_d && rst_n;
    assign bus.mem_read   = mem_read_d;
    assign bus.mem_addr   = mem_addr_d;
endmodule

// File: tb/tb_i_cache.sv
// Directed bench for the instruction cache: cold/conflict misses, sequential
// hits, address change during refill, reset mid-refill and idle requests.
module tb_i_cache;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    localparam logic [127:0] LINE0 = 128'h00000013_00000013_00000013_00008067;
    localparam logic [127:0] LINE8 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    localparam logic [127:0] LINE1 = 128'h11110003_11110002_11110001_11110000;
    localparam logic [127:0] LINE2 = 128'h22220003_22220002_22220001_22220000;
    localparam logic [127:0] LINE3 = 128'h33330003_33330002_33330001_33330000;

    i_cache_if bus ();

    i_cache #(.NUM_LINES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns past the next rising edge, where new inputs are applied
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.proc_read = 1'b0;
        bus.proc_addr = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        #3;
        check("reset_stall",    128'(bus.proc_stall), 128'(0));
        check("reset_mem_read", 128'(bus.mem_read),   128'(0));
        check("reset_mem_addr", 128'(bus.mem_addr),   128'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // Idle request: no stall, no refill, no state change
        bus.proc_addr = 30'h123;
        #1;
        check("idle_stall",    128'(bus.proc_stall), 128'(0));
        check("idle_mem_read", 128'(bus.mem_read),   128'(0));
        tick();
        #1;
        check("idle_next_mem_read", 128'(bus.mem_read), 128'(0));

        // Cold miss at address 0
        tick();
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h0;
        #1;
        check("cold_stall_same_cycle", 128'(bus.proc_stall), 128'(1));
        check("cold_mem_read_idle",    128'(bus.mem_read),   128'(0));
        tick();
        #1;
        check("cold_mem_read", 128'(bus.mem_read), 128'(1));
        check("cold_mem_addr", 128'(bus.mem_addr), 128'(0));
        check("cold_stall",    128'(bus.proc_stall), 128'(1));
        tick();
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = LINE0;
        #1;
        check("cold_stall_ready_cycle", 128'(bus.proc_stall), 128'(1));
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
        check("cold_hit_stall", 128'(bus.proc_stall), 128'(0));
        check("cold_hit_rdata", 128'(bus.proc_rdata), 128'(32'h00008067));
        check("cold_hit_mem_read", 128'(bus.mem_read), 128'(0));

        // Sequential hits on words 1..3
        for (int w = 1; w <= 3; w++) begin
            tick();
            bus.proc_addr = 30'(w);
            #1;
            check($sformatf("seq_stall_w%0d", w),    128'(bus.proc_stall), 128'(0));
            check($sformatf("seq_rdata_w%0d", w),    128'(bus.proc_rdata), 128'(32'h00000013));
            check($sformatf("seq_mem_read_w%0d", w), 128'(bus.mem_read),   128'(0));
        end

        // Conflict miss: 0x20 maps to index 0 with tag 1
        tick();
        bus.proc_addr = 30'h20;
        #1;
        check("conf_stall", 128'(bus.proc_stall), 128'(1));
        tick();
        #1;
        check("conf_mem_read", 128'(bus.mem_read), 128'(1));
        check("conf_mem_addr", 128'(bus.mem_addr), 128'(28'h8));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = LINE8;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("conf_hit_stall", 128'(bus.proc_stall), 128'(0));
        check("conf_hit_rdata", 128'(bus.proc_rdata), 128'(32'hAAAA0000));
        bus.proc_addr = 30'h0;
        #1;
        check("conf_back_stall", 128'(bus.proc_stall), 128'(1));
        tick();
        #1;
        check("conf_back_mem_addr", 128'(bus.mem_addr), 128'(0));
        check("conf_back_mem_read", 128'(bus.mem_read), 128'(1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = LINE0;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("conf_back_hit_rdata", 128'(bus.proc_rdata), 128'(32'h00008067));
        check("conf_back_hit_stall", 128'(bus.proc_stall), 128'(0));

        // Address change during refill
        tick();
        bus.proc_addr = 30'h4;
        #1;
        check("chg_stall", 128'(bus.proc_stall), 128'(1));
        tick();
        bus.proc_addr = 30'h8;
        #1;
        check("chg_mem_addr", 128'(bus.mem_addr), 128'(1));
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = LINE1;
        #1;
        check("chg_mem_addr_ready", 128'(bus.mem_addr), 128'(1));
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("chg_idle_stall",    128'(bus.proc_stall), 128'(1));
        check("chg_idle_mem_read", 128'(bus.mem_read),   128'(0));
        tick();
        #1;
        check("chg_line2_mem_addr", 128'(bus.mem_addr), 128'(2));
        check("chg_line2_mem_read", 128'(bus.mem_read), 128'(1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = LINE2;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("chg_line2_rdata", 128'(bus.proc_rdata), 128'(32'h22220000));
        check("chg_line2_stall", 128'(bus.proc_stall), 128'(0));
        bus.proc_addr = 30'h4;
        #1;
        check("chg_line1_rdata", 128'(bus.proc_rdata), 128'(32'h11110000));
        check("chg_line1_stall", 128'(bus.proc_stall), 128'(0));
        bus.proc_addr = 30'h5;
        #1;
        check("chg_line1_w1_rdata", 128'(bus.proc_rdata), 128'(32'h11110001));

        // Reset in the middle of a refill
        tick();
        bus.proc_addr = 30'hC;
        #1;
        check("rst_miss_stall", 128'(bus.proc_stall), 128'(1));
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_read", 128'(bus.mem_read),   128'(0));
        check("rst_mid_stall",    128'(bus.proc_stall), 128'(0));
        check("rst_mid_mem_addr", 128'(bus.mem_addr),   128'(0));
        tick();
        rst_n         = 1'b1;
        bus.proc_read = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = LINE3;
        #1;
        check("rst_late_ready_mem_read", 128'(bus.mem_read), 128'(0));
        tick();
        bus.mem_ready = 1'b0;
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h0;
        #1;
        check("rst_line0_invalid", 128'(bus.proc_stall), 128'(1));
        bus.proc_addr = 30'hC;
        #1;
        check("rst_line3_invalid", 128'(bus.proc_stall), 128'(1));
        tick();
        #1;
        check("rst_refill_mem_addr", 128'(bus.mem_addr), 128'(3));
        check("rst_refill_mem_read", 128'(bus.mem_read), 128'(1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = LINE3;
        tick();
        bus.mem_ready = 1'b0;
        bus.proc_addr = 30'hE;
        #1;
        check("rst_refill_rdata", 128'(bus.proc_rdata), 128'(32'h33330002));
        check("rst_refill_stall", 128'(bus.proc_stall), 128'(0));

        tick();
        bus.proc_read = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i_cache.md
I_CACHE -- requirements
Module: I_cache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, meaning the number of direct-mapped lines (power of two, >=2), each line holding 4 words.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port proc_read  input  1  fetch request from instruction_fetch (I_ren).
REQ-005 SHALL have port proc_addr  input  30  word address (I_addr).
REQ-006 SHALL have port proc_rdata  output  32  instruction word, raw memory byte order (instruction_in).
REQ-007 SHALL have port proc_stall  output  1  fetch must hold (memory_stall).
REQ-008 SHALL have port mem_read  output  1  line refill request to memory.
REQ-009 SHALL have port mem_addr  output  28  line address.
REQ-010 SHALL have port mem_rdata  input  128  refill line, word 0 in bits [31:0].
REQ-011 SHALL have port mem_ready  input  1  one-cycle pulse; mem_rdata is valid in that cycle.

Function
REQ-012 SHALL split proc_addr as offset=[1:0], index=next log2(NUM_LINES) bits, and tag=remaining upper bits (NUM_LINES=8: index [4:2], tag [29:5]).
REQ-013 SHALL store a valid bit, a tag and 128 data bits per line; there is no write path and no dirty state.
REQ-014 SHALL detect hit combinationally as valid[index] AND stored tag==tag.
REQ-015 SHALL drive proc_rdata combinationally with word[offset] of the indexed line in the same cycle as proc_addr (zero-latency hit); proc_rdata is don't-care while proc_stall=1.
REQ-016 SHALL use FSM states IDLE and REFILL.
REQ-017 SHALL, in IDLE with proc_read=1 and miss, assert proc_stall in that same cycle, capture proc_addr[29:2] into a miss-address register, and enter REFILL.
REQ-018 SHALL, in REFILL, hold mem_read=1 and mem_addr=miss-address register, and assert proc_stall=1 every cycle.
REQ-019 SHALL, in REFILL when mem_ready=1, write mem_rdata, the miss tag and valid=1 into the miss line, then return to IDLE.
REQ-020 SHALL re-evaluate proc_addr in the first IDLE cycle after a refill: a hit there deasserts proc_stall; a miss starts a new refill.
REQ-021 SHALL hold mem_read=0 and mem_addr=0 in IDLE.
REQ-022 SHALL keep proc_stall=0 in IDLE when proc_read=0 or on a hit.
REQ-023 SHALL ignore proc_addr changes during REFILL; the refill always targets the captured miss address.
REQ-024 SHALL ignore mem_ready in IDLE (no array update).
REQ-025 SHALL, on refill into an occupied index with a different tag, overwrite that line (replacement is direct-mapped).

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-REFILL, immediately force state=IDLE, clear all valid bits and the miss-address register, and drive mem_read=0, mem_addr=0 and proc_stall=0; data and tag arrays need no reset.
REQ-027 SHALL remain in IDLE after rst_n deasserts until the first clk edge with proc_read=1; a refill aborted by reset is not resumed, and a late mem_ready is ignored.

Verification
REQ-028 SHALL cover cold miss: after reset, proc_read=1, proc_addr=0 -> proc_stall=1 same cycle, mem_read=1 and mem_addr=0 next cycle; memory returns mem_ready with mem_rdata=128'h00000013_00000013_00000013_00008067 after 5 cycles -> next cycle proc_stall=0 and proc_rdata=32'h00008067.
REQ-029 SHALL cover a sequential hit: after the test above, proc_addr=1,2,3 on consecutive cycles -> proc_stall=0 and proc_rdata=32'h00000013 each cycle, with mem_read=0 throughout.
REQ-030 SHALL cover a conflict miss with NUM_LINES=8: proc_addr=30'h20 (same index 0, tag 1) -> refill with mem_addr=28'h8; then proc_addr=0 -> miss again with mem_addr=0.
REQ-031 SHALL cover an address change during refill: miss at proc_addr=4, then proc_addr=8 during REFILL -> mem_addr stays 1; after mem_ready, one IDLE cycle, then a miss for line 2 with mem_addr=2.
REQ-032 SHALL cover reset mid-refill: rst_n=0 two cycles into REFILL -> mem_read=0 and proc_stall=0 without waiting for a clock edge; a mem_ready arriving after reset release -> no line becomes valid, and proc_read to the same address misses again.
REQ-033 SHALL cover an idle request: proc_read=0 with any proc_addr -> proc_stall=0 and mem_read=0, with no state change.
